// File: rtl/ppi_bsr_port.sv
// rtl/ppi_bsr_port.sv - PPI port C bit set/reset engine with toggle and timed pulse
`timescale 1ns/1ps
module ppi_bsr_port #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter int CW        = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             WR,
    input  logic [CW-1:0]    Control,
    output logic [WIDTH-1:0] Output,
    output logic             Busy
);
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    if (CW < SEL_W + 4) begin : g_cw_chk
        $error("ppi_bsr_port: CW must be >= SEL_W+4");
    end
    if (WIDTH != (1 << SEL_W) || WIDTH < 2) begin : g_width_chk
        $error("ppi_bsr_port: WIDTH must equal 2**SEL_W and be >= 2");
    end
    if (PULSE_LEN < 1) begin : g_len_chk
        $error("ppi_bsr_port: PULSE_LEN must be >= 1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] psel_q, psel_d;
    logic             ppol_q, ppol_d;

    logic             accept;
    logic             mode_set;
    logic [SEL_W-1:0] sel;
    logic [1:0]       op;
    logic             v;
    logic [CW-1:0]    unused_ctrl;

    assign accept      = ENABLE & WR;
    assign mode_set    = Control[CW-1];
    assign sel         = Control[SEL_W:1];
    assign op          = Control[SEL_W+2:SEL_W+1];
    assign v           = Control[0];
    assign unused_ctrl = Control;

    always_comb begin
        out_d  = out_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        psel_d = psel_q;
        ppol_d = ppol_q;

        // Timer first; an accepted word below overrides whatever expiry did.
        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                out_d[psel_q] = ~ppol_q;
                busy_d        = 1'b0;
            end
        end

        if (accept) begin
            if (mode_set) begin
                out_d  = '0;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                case (op)
                    2'b00: begin
                        out_d[sel] = v;
                        if (busy_q && psel_q == sel) busy_d = 1'b0;
                    end
                    2'b01: begin
                        out_d[sel] = ~out_q[sel];
                        if (busy_q && psel_q == sel) busy_d = 1'b0;
                    end
                    2'b10: begin
                        if (busy_q) out_d[psel_q] = ~ppol_q;
                        out_d[sel] = v;
                        psel_d     = sel;
                        ppol_d     = v;
                        cnt_d      = CNT_W'(PULSE_LEN);
                        busy_d     = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            psel_q <= '0;
            ppol_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            psel_q <= psel_d;
            ppol_q <= ppol_d;
        end
    end

    assign Output = out_q;
    assign Busy   = busy_q;
endmodule

// File: tb/tb_ppi_bsr_port.sv
// tb/tb_ppi_bsr_port.sv - scoreboard bench for ppi_bsr_port, default and wide/short-pulse builds
`timescale 1ns/1ps
module tb_ppi_bsr_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  ctrl_a = '0;
    logic [7:0]  ctrl_b = '0;
    logic [7:0]  out_a;
    logic        busy_a;
    logic [15:0] out_b;
    logic        busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppi_bsr_port #(.WIDTH(8), .SEL_W(3), .CW(8), .PULSE_LEN(4)) dut_a (
        .CLK(clk), .RESET(rst), .ENABLE(en), .WR(wr),
        .Control(ctrl_a), .Output(out_a), .Busy(busy_a)
    );

    ppi_bsr_port #(.WIDTH(16), .SEL_W(4), .CW(8), .PULSE_LEN(1)) dut_b (
        .CLK(clk), .RESET(rst), .ENABLE(en), .WR(wr),
        .Control(ctrl_b), .Output(out_b), .Busy(busy_b)
    );

    typedef struct {
        logic [7:0]  oa;
        logic        ba;
        logic [15:0] ob;
        logic        bb;
    } exp_t;
    exp_t exp_q[$];

    // Reference: pulse restore tracked as an absolute edge number, not a countdown.
    logic [15:0] m_out[2];
    bit          m_busy[2];
    int          m_psel[2];
    bit          m_ppol[2];
    int          m_end[2];
    int          edge_n = 0;

    task automatic model(input int i, input bit r, input bit acc, input bit mode,
                         input int op, input int sel, input bit v);
        int          len;
        logic [15:0] nx;
        bit          nb;
        len = (i == 0) ? 4 : 1;
        if (r) begin
            m_out[i]  = '0;
            m_busy[i] = 0;
            return;
        end
        nx = m_out[i];
        nb = m_busy[i];
        if (m_busy[i] && edge_n == m_end[i]) begin
            nx[m_psel[i]] = ~m_ppol[i];
            nb = 0;
        end
        if (acc) begin
            if (mode) begin
                nx = '0;
                nb = 0;
            end else if (op == 0 || op == 1) begin
                nx[sel] = (op == 0) ? v : ~m_out[i][sel];
                if (m_busy[i] && m_psel[i] == sel) nb = 0;
            end else if (op == 2) begin
                if (m_busy[i]) nx[m_psel[i]] = ~m_ppol[i];
                nx[sel]   = v;
                m_psel[i] = sel;
                m_ppol[i] = v;
                m_end[i]  = edge_n + len;
                nb        = 1;
            end
        end
        m_out[i]  = nx;
        m_busy[i] = nb;
    endtask

    task automatic step(input bit r, input bit e, input bit w, input bit mode,
                        input int op, input int sel, input bit v, input bit ign);
        exp_t x;
        @(negedge clk);
        rst    = r;
        en     = e;
        wr     = w;
        ctrl_a = {mode, ign, op[1:0], sel[2:0], v};
        ctrl_b = {mode, op[1:0], sel[3:0], v};
        edge_n++;
        model(0, r, e && w, mode, op, sel % 8, v);
        model(1, r, e && w, mode, op, sel % 16, v);
        x.oa = m_out[0][7:0];
        x.ba = m_busy[0];
        x.ob = m_out[1];
        x.bb = m_busy[1];
        exp_q.push_back(x);
    endtask

    task automatic word(input logic [7:0] c);
        step(0, 1, 1, c[7], int'(c[5:4]), int'(c[3:1]), c[0], c[6]);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [7:0] exp_o, input logic exp_b);
        total++;
        if (out_a !== exp_o || busy_a !== exp_b) begin
            bad++;
            $display("FAIL %s: got out=%h busy=%b want out=%h busy=%b",
                     name, out_a, busy_a, exp_o, exp_b);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total += 2;
            if (out_a !== e.oa || busy_a !== e.ba) begin
                bad++;
                $display("FAIL sb_a t=%0t: got out=%h busy=%b want out=%h busy=%b",
                         $time, out_a, busy_a, e.oa, e.ba);
            end
            if (out_b !== e.ob || busy_b !== e.bb) begin
                bad++;
                $display("FAIL sb_b t=%0t: got out=%h busy=%b want out=%h busy=%b",
                         $time, out_b, busy_b, e.ob, e.bb);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_out[i] = '0; m_busy[i] = 0; m_psel[i] = 0; m_ppol[i] = 0; m_end[i] = 0;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("reset", 8'h00, 1'b0);
        step(0, 0, 1, 0, 3, 7, 1, 0);
        idle();
        chk("enable_low", 8'h00, 1'b0);

        word(8'h0F); idle(); chk("set_b7", 8'h80, 1'b0);
        word(8'h03); idle(); chk("set_b1", 8'h82, 1'b0);
        word(8'h0E); idle(); chk("clr_b7", 8'h02, 1'b0);
        word(8'h1B); idle(); chk("tog_b5_on", 8'h22, 1'b0);
        word(8'h1B); idle(); chk("tog_b5_off", 8'h02, 1'b0);

        word(8'h27);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("pulse_hold", 8'h0A, 1'b1);
        end
        idle();
        chk("pulse_end", 8'h02, 1'b0);

        word(8'h27); idle(); word(8'h23);
        idle(); chk("repulse", 8'h02, 1'b1);
        repeat (4) idle();
        chk("repulse_end", 8'h00, 1'b0);

        word(8'h27); idle(); word(8'h80);
        idle(); chk("mode_abort", 8'h00, 1'b0);
        word(8'h27); idle(); step(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) idle();
        chk("reset_abort", 8'h00, 1'b0);

        word(8'h27); idle(); idle(); idle(); word(8'h06);
        idle(); chk("expiry_clash", 8'h00, 1'b0);
        word(8'h47); idle(); chk("ignored_bit", 8'h08, 1'b0);
        word(8'h37); idle(); chk("reserved_op", 8'h08, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle();

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
